mem_image_writer: RTL and testbench

Streams a range of simulator memory out as ASCII in the team's octal load-image format, so that a memory image dumped after execution can be fed straight back to the image loader. It is the writer for the loader's parser. It sits beside the PDP-11 ISA core on the memory port. It emits the header lines `*` (data offset) and `@` (start address), then one `-` line per 16-bit word, over a byte-wide valid/ready stream.

---
 rtl/mem_image_writer.sv | 185 ++++++++++++++++++
 tb/tb_mem_image_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_image_writer.sv
// mem_image_writer: streams a range of memory as ASCII octal load-image text.
// Emits "*oooooo\n" (data offset), "@oooooo\n" (start address), then one
// "-oooooo\n" line per 16-bit word over a byte-wide valid/ready stream.
// Optional feature macro: MEM_IMAGE_WRITER_CHECKSUM_EN adds a trailing
// "#oooooo\n" line carrying the 16-bit wrapping sum of all dumped words.
module mem_image_writer #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       dataOffset,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [15:0]       wordCount,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [15:0]       memData,
    input  logic              memValid,
    output logic              txValid,
    output logic [7:0]        txByte,
    input  logic              txReady,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR_STAR,
        S_HDR_AT,
        S_FETCH,
        S_EMIT,
        S_CKSUM,
        S_FINISH
    } state_t;

    // State entered once the last word line (or the empty header) is sent.
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
    localparam state_t TAIL = S_CKSUM;
`else
    localparam state_t TAIL = S_FINISH;
`endif

    state_t            state_q, state_d;
    logic [2:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       line_q, line_d;
    logic [15:0]       offset_q, offset_d;
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
    logic [15:0]       sum_q, sum_d;
`endif

    logic accept;
    logic line_end;
    logic capture;
    logic [7:0]  sym;
    logic [15:0] val;
    logic [2:0]  digit;

    assign accept   = txValid && txReady;
    assign line_end = accept && (byte_cnt_q == 3'd7);
    assign capture  = memReq && memValid;

    // State and datapath registers, cleared asynchronously on reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            line_q     <= '0;
            offset_q   <= '0;
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            line_q     <= line_d;
            offset_q   <= offset_d;
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    // Next-state logic: headers, then fetch/emit per word, then optional trailer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_HDR_STAR;
            S_HDR_STAR: if (line_end) state_d = S_HDR_AT;
            S_HDR_AT:   if (line_end) state_d = (word_cnt_q == 16'd0) ? TAIL : S_FETCH;
            S_FETCH:    if (memValid) state_d = S_EMIT;
            S_EMIT:     if (line_end) state_d = (word_cnt_q == 16'd1) ? TAIL : S_FETCH;
            S_CKSUM:    if (line_end) state_d = S_FINISH;
            S_FINISH:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Counter, address and capture-register updates.
    always_comb begin
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        line_d     = line_q;
        offset_d   = offset_q;
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (state_q == S_IDLE && start) begin
            byte_cnt_d = '0;
            word_cnt_d = wordCount;
            addr_d     = {startAddr[ADDR_W-1:1], 1'b0};
            offset_d   = dataOffset;
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
            sum_d      = '0;
`endif
        end
        // The 3-bit counter wraps 7 -> 0, which is exactly the start of the next line.
        if (accept) begin
            byte_cnt_d = byte_cnt_q + 3'd1;
        end
        if (capture) begin
            line_d = memData;
            addr_d = addr_q + ADDR_W'(2);
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
            sum_d  = sum_q + memData;
`endif
        end
        if (state_q == S_EMIT && line_end) begin
            word_cnt_d = word_cnt_q - 16'd1;
        end
    end

    // Outputs decoded from state; the character is built from the line's symbol and value.
    always_comb begin
        memReq  = (state_q == S_FETCH);
        memAddr = addr_q;
        done    = (state_q == S_FINISH);
        busy    = (state_q == S_HDR_STAR) || (state_q == S_HDR_AT) ||
                  (state_q == S_FETCH)    || (state_q == S_EMIT)   ||
                  (state_q == S_CKSUM);
        txValid = (state_q == S_HDR_STAR) || (state_q == S_HDR_AT) ||
                  (state_q == S_EMIT)     || (state_q == S_CKSUM);

        sym = 8'h00;
        val = 16'h0000;
        case (state_q)
            S_HDR_STAR: begin sym = 8'h2A; val = offset_q;   end
            S_HDR_AT:   begin sym = 8'h40; val = 16'(addr_q); end
            S_EMIT:     begin sym = 8'h2D; val = line_q;     end
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
            S_CKSUM:    begin sym = 8'h23; val = sum_q;      end
`endif
            default:    begin sym = 8'h00; val = 16'h0000;   end
        endcase

        digit = 3'd0;
        case (byte_cnt_q)
            3'd1:    digit = {2'b00, val[15]};
            3'd2:    digit = val[14:12];
            3'd3:    digit = val[11:9];
            3'd4:    digit = val[8:6];
            3'd5:    digit = val[5:3];
            3'd6:    digit = val[2:0];
            default: digit = 3'd0;
        endcase

        txByte = 8'h00;
        if (txValid) begin
            if (byte_cnt_q == 3'd0) begin
                txByte = sym;
            end else if (byte_cnt_q == 3'd7) begin
                txByte = 8'h0A;
            end else begin
                txByte = 8'h30 + {5'b00000, digit};
            end
        end
    end

endmodule

// File: tb/tb_mem_image_writer.sv
// Directed bench for mem_image_writer: byte stream, timing, reset and wrap checks.
// Expectations follow MEM_IMAGE_WRITER_CHECKSUM_EN when the bench is built with it.
module tb_mem_image_writer;

    logic        clock;
    logic        reset;
    logic        start;
    logic [15:0] dataOffset;
    logic [15:0] startAddr;
    logic [15:0] wordCount;
    logic        memReq;
    logic [15:0] memAddr;
    logic [15:0] memData;
    logic        memValid;
    logic        txValid;
    logic [7:0]  txByte;
    logic        txReady;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    byte         rx[$];
    logic [15:0] req_addrs[$];
    int          req_cycles = 0;
    int          req_run = 0;
    logic [15:0] prev_addr = '0;
    int          mem_lat = 0;
    int          rdy_mode = 0;
    int          rdy_phase = 0;
    bit          stall_prev = 0;
    logic [7:0]  stall_byte = '0;

    mem_image_writer #(.ADDR_W(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .dataOffset (dataOffset),
        .startAddr  (startAddr),
        .wordCount  (wordCount),
        .memReq     (memReq),
        .memAddr    (memAddr),
        .memData    (memData),
        .memValid   (memValid),
        .txValid    (txValid),
        .txByte     (txByte),
        .txReady    (txReady),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 0;
    always #5 clock = ~clock;

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'o001000: return 16'o012737;
            16'o177776: return 16'o177777;
            16'o000000: return 16'o000002;
            default:    return 16'o052525;
        endcase
    endfunction

    // Sink: drives txReady, records accepted bytes, checks stability under stall.
    always @(negedge clock) begin
        rdy_phase++;
        txReady = (rdy_mode == 0) || (rdy_phase % 3 == 0);
        if (reset && stall_prev) begin
            check(32'(txValid), 32'd1, "stall_valid");
            check(32'(txByte), 32'(stall_byte), "stall_byte");
        end
        if (reset && txValid && txReady) rx.push_back(txByte);
        stall_prev = reset && txValid && !txReady;
        stall_byte = txByte;
    end

    // Memory: answers after mem_lat extra cycles, logs request addresses.
    always @(negedge clock) begin
        if (!reset) begin
            memValid = 0;
            memData  = '0;
            req_run  = 0;
        end else if (memReq) begin
            if (req_run == 0) req_addrs.push_back(memAddr);
            else check(32'(memAddr), 32'(prev_addr), "memaddr_stable");
            prev_addr = memAddr;
            req_run++;
            req_cycles++;
            memValid = (req_run > mem_lat);
            memData  = memValid ? mem_word(memAddr) : 16'h0000;
        end else begin
            req_run  = 0;
            memValid = 0;
            memData  = '0;
        end
    end

    task automatic check_stream(input string exp, input string tag);
        check(32'(rx.size()), 32'(exp.len()), {tag, "_len"});
        for (int i = 0; i < exp.len() && i < rx.size(); i++) begin
            byte e;
            e = exp[i];
            check(32'(rx[i]), 32'(e), $sformatf("%s_byte%0d", tag, i));
        end
    endtask

    task automatic run_dump(input logic [15:0] off, input logic [15:0] sa, input logic [15:0] wc,
                            input bit pulse_again, input string exp, input int exp_busy,
                            input string tag);
        int busy_cycles;
        bit seen_done;
        rx.delete();
        req_addrs.delete();
        req_cycles = 0;
        seen_done = 0;
        @(negedge clock);
        dataOffset = off;
        startAddr  = sa;
        wordCount  = wc;
        start      = 1;
        @(negedge clock);
        start = 0;
        #1;
        check(32'(busy), 32'd1, {tag, "_busy_rise"});
        check(32'(txValid), 32'd1, {tag, "_valid_rise"});
        check(32'(txByte), 32'h2A, {tag, "_first_star"});
        busy_cycles = 1;
        for (int i = 0; i < 3000 && !seen_done; i++) begin
            @(negedge clock);
            #1;
            if (done) seen_done = 1;
            else if (busy) busy_cycles++;
            if (pulse_again && i == 4) start = 1;
            if (pulse_again && i == 5) start = 0;
        end
        start = 0;
        check(32'(seen_done), 32'd1, {tag, "_done_seen"});
        check(32'(busy), 32'd0, {tag, "_busy_at_done"});
        if (exp_busy >= 0) check(32'(busy_cycles), 32'(exp_busy), {tag, "_busy_cycles"});
        @(negedge clock);
        #1;
        check(32'(done), 32'd0, {tag, "_done_pulse"});
        check_stream(exp, tag);
    endtask

    initial begin
        string e1, e0, ew;
        int tail;
        int wait_ok;
`ifdef MEM_IMAGE_WRITER_CHECKSUM_EN
        e1   = "*000100\n@001000\n-012737\n#012737\n";
        e0   = "*000100\n@001000\n#000000\n";
        ew   = "*000000\n@177776\n-177777\n-000002\n#000001\n";
        tail = 8;
`else
        e1   = "*000100\n@001000\n-012737\n";
        e0   = "*000100\n@001000\n";
        ew   = "*000000\n@177776\n-177777\n-000002\n";
        tail = 0;
`endif
        reset = 0; start = 0; dataOffset = '0; startAddr = '0; wordCount = '0;
        txReady = 1; memValid = 0; memData = '0;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        check(32'({memReq, memAddr, txValid, txByte, busy, done}), 32'd0, "reset_outputs");
        @(negedge clock);
        reset = 1;

        // Single word, sink ready, one-cycle memory
        rdy_mode = 0; mem_lat = 0;
        run_dump(16'o000100, 16'o001000, 16'd1, 0, e1, 25 + tail, "single");
        check(32'(req_addrs.size()), 32'd1, "single_nreq");
        if (req_addrs.size() > 0) check(32'(req_addrs[0]), 32'o001000, "single_addr");

        // Zero words: headers only, no memory request
        run_dump(16'o000100, 16'o001000, 16'd0, 0, e0, 16 + tail, "zero");
        check(32'(req_cycles), 32'd0, "zero_no_memreq");

        // Back-pressure and slow memory
        rdy_mode = 1; mem_lat = 4;
        run_dump(16'o000100, 16'o001000, 16'd1, 0, e1, -1, "stall");
        check(32'(req_cycles), 32'd5, "stall_req_cycles");

        // Address wrap (odd start address rounded down), also exercises checksum wrap
        rdy_mode = 0; mem_lat = 0;
        run_dump(16'o000000, 16'o177777, 16'd2, 0, ew, 34 + tail, "wrap");
        check(32'(req_addrs.size()), 32'd2, "wrap_nreq");
        if (req_addrs.size() > 1) begin
            check(32'(req_addrs[0]), 32'o177776, "wrap_addr0");
            check(32'(req_addrs[1]), 32'o000000, "wrap_addr1");
        end

        // Reset during the third digit of the word line
        rx.delete();
        @(negedge clock);
        dataOffset = 16'o000100; startAddr = 16'o001000; wordCount = 16'd1; start = 1;
        @(negedge clock);
        start = 0;
        wait_ok = 0;
        for (int i = 0; i < 200 && wait_ok == 0; i++) begin
            #2;
            if (rx.size() == 20) wait_ok = 1;
            else @(negedge clock);
        end
        check(32'(wait_ok), 32'd1, "midline_reached");
        check(32'(txByte), 32'h32, "midline_third_digit");
        reset = 0;
        #1;
        check(32'({memReq, memAddr, txValid, txByte, busy, done}), 32'd0, "async_reset_outputs");
        repeat (2) @(negedge clock);
        reset = 1;

        // Restart after reset, with a start pulse while busy that must be ignored
        run_dump(16'o000100, 16'o001000, 16'd1, 1, e1, 25 + tail, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
